// File: rtl/dot_pkg.sv
// Shared widths, round modes and stage-valid type for the dot_pipe datapath.
// Built with or without DOT_PIPE_SATURATE_EN (see dot_pipe.sv).
package dot_pkg;

    localparam int MAX_ELEM = 8;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } round_e;

    typedef struct packed {
        logic v1;
        logic v2;
        logic v3;
    } stage_vld_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int prod_w(input int dw);
        return 2 * dw;
    endfunction

    // One extra bit per tree level keeps the sum exact.
    function automatic int sum_w(input int dw, input int n);
        return prod_w(dw) + clog2(n);
    endfunction

endpackage

// File: rtl/dot_adder_tree.sv
// Combinational balanced adder tree; exact signed sum of N_ELEM terms.
// Pads to a power of two with zero leaves.
module dot_adder_tree
    import dot_pkg::*;
#(
    parameter int N_ELEM = 3,
    parameter int IN_W   = 64
) (
    input  logic [N_ELEM-1:0][IN_W-1:0]            terms,
    output logic signed [IN_W+clog2(N_ELEM)-1:0]   sum
);

    localparam int LVL = clog2(N_ELEM);
    localparam int NP  = 1 << LVL;
    localparam int SW  = IN_W + LVL;

    for (genvar l = 0; l <= LVL; l++) begin : g_lvl
        logic signed [SW-1:0] n [NP >> l];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < NP; i++) begin : g_in
                if (i < N_ELEM) begin : g_term
                    assign n[i] = SW'($signed(terms[i]));
                end else begin : g_pad
                    assign n[i] = '0;
                end
            end
        end else begin : g_add
            for (genvar j = 0; j < (NP >> l); j++) begin : g_pair
                assign n[j] = g_lvl[l-1].n[2*j] + g_lvl[l-1].n[2*j+1];
            end
        end
    end

    assign sum = g_lvl[LVL].n[0];

endmodule

// File: rtl/dot_pipe.sv
// 3-stage fixed-point dot product between a FWFT input FIFO and an output FIFO.
// DOT_PIPE_SATURATE_EN: clamp out-of-range results instead of wrapping.
module dot_pipe
    import dot_pkg::*;
#(
    parameter int N_ELEM     = 3,
    parameter int DATA_WIDTH = 32,
    parameter int Q_BITS     = 10,
    parameter int ROUND      = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_ELEM-1:0][DATA_WIDTH-1:0]  x,
    input  logic [N_ELEM-1:0][DATA_WIDTH-1:0]  y,
    input  logic                               in_empty,
    output logic                               in_rd_en,
    output logic signed [DATA_WIDTH-1:0]       out,
    input  logic                               out_full,
    output logic                               out_wr_en,
    output logic                               ovf
);

    localparam int PW = prod_w(DATA_WIDTH);
    localparam int SW = sum_w(DATA_WIDTH, N_ELEM);

    localparam logic signed [SW:0] RND_ADD =
        (ROUND == int'(RND_HALF_UP)) ?
        ({{SW{1'b0}}, 1'b1} << (Q_BITS - 1)) : '0;

    localparam logic signed [DATA_WIDTH-1:0] MAX_VAL =
        {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};

    stage_vld_t                  vld;
    logic                        advance;
    logic [N_ELEM-1:0][PW-1:0]   prod_d;
    logic [N_ELEM-1:0][PW-1:0]   prod_q;
    logic signed [SW-1:0]        tree_sum;
    logic signed [SW-1:0]        sum_q;

    logic signed [SW:0]          rnd_sum;
    logic signed [SW:0]          shifted;
    logic [SW-DATA_WIDTH+1:0]    top_bits;
    logic                        out_of_range;
    logic signed [DATA_WIDTH-1:0] res;

    // The whole pipe freezes only when a finished result cannot be pushed.
    assign advance   = !(vld.v3 && out_full);
    assign in_rd_en  = !in_empty && advance;
    assign out_wr_en = vld.v3 && !out_full;

    always_comb begin
        prod_d = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            prod_d[i] = PW'($signed(x[i])) * PW'($signed(y[i]));
        end
    end

    dot_adder_tree #(
        .N_ELEM (N_ELEM),
        .IN_W   (PW)
    ) u_tree (
        .terms  (prod_q),
        .sum    (tree_sum)
    );

    // Upper bits beyond the result sign must all match the sign to fit.
    always_comb begin
        rnd_sum      = (SW+1)'(sum_q) + RND_ADD;
        shifted      = rnd_sum >>> Q_BITS;
        top_bits     = shifted[SW:DATA_WIDTH-1];
        out_of_range = !((&top_bits) || !(|top_bits));
        res          = shifted[DATA_WIDTH-1:0];
`ifdef DOT_PIPE_SATURATE_EN
        if (out_of_range) begin
            res = shifted[SW] ? MIN_VAL : MAX_VAL;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld    <= '0;
            prod_q <= '0;
            sum_q  <= '0;
            out    <= '0;
            ovf    <= 1'b0;
        end else if (advance) begin
            vld.v1 <= in_rd_en;
            vld.v2 <= vld.v1;
            vld.v3 <= vld.v2;
            if (in_rd_en) begin
                prod_q <= prod_d;
            end
            if (vld.v1) begin
                sum_q <= tree_sum;
            end
            if (vld.v2) begin
                out <= res;
                if (out_of_range) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_pipe.sv
// Randomized + directed bench for dot_pipe: N=3 round/trunc and N=4 instances.
// Expected results come from a 128-bit arithmetic reference and age-based timing model.
module tb_dot_pipe;

    localparam int DW = 32;
    localparam int QB = 10;

    typedef struct {
        logic [3:0][DW-1:0] a;
        logic [3:0][DW-1:0] b;
        bit                 g;
        logic [DW-1:0]      gr;
        logic [DW-1:0]      gt;
        logic [DW-1:0]      g4;
    } stim_t;

    typedef struct {
        logic [DW-1:0] er;
        logic [DW-1:0] et;
        logic [DW-1:0] e4;
        bit            vr;
        bit            vt;
        bit            v4;
        bit            g;
        logic [DW-1:0] gr;
        logic [DW-1:0] gt;
        logic [DW-1:0] g4;
        int            adv;
    } exp_t;

    logic               clock;
    logic               reset;
    logic [3:0][DW-1:0] xb;
    logic [3:0][DW-1:0] yb;
    logic               in_empty;
    logic               out_full;
    logic               rd_r, rd_t, rd4;
    logic               wr_r, wr_t, wr4;
    logic               ovf_r, ovf_t, ovf4;
    logic [DW-1:0]      out_r, out_t, out4;

    stim_t sq[$];
    exp_t  q[$];
    exp_t  e;
    stim_t s;

    int n_chk;
    int n_pass;
    int n_out;
    int bp_mode;
    int pc;
    bit gap;
    bit took;
    bit head;
    bit adv;
    bit ovm_r, ovm_t, ovm4;
    int base;

    dot_pipe #(.N_ELEM(3), .DATA_WIDTH(DW), .Q_BITS(QB), .ROUND(1)) dut_r (
        .clock(clock), .reset(reset), .x(xb[2:0]), .y(yb[2:0]),
        .in_empty(in_empty), .in_rd_en(rd_r), .out(out_r),
        .out_full(out_full), .out_wr_en(wr_r), .ovf(ovf_r));

    dot_pipe #(.N_ELEM(3), .DATA_WIDTH(DW), .Q_BITS(QB), .ROUND(0)) dut_t (
        .clock(clock), .reset(reset), .x(xb[2:0]), .y(yb[2:0]),
        .in_empty(in_empty), .in_rd_en(rd_t), .out(out_t),
        .out_full(out_full), .out_wr_en(wr_t), .ovf(ovf_t));

    dot_pipe #(.N_ELEM(4), .DATA_WIDTH(DW), .Q_BITS(QB), .ROUND(1)) dut4 (
        .clock(clock), .reset(reset), .x(xb), .y(yb),
        .in_empty(in_empty), .in_rd_en(rd4), .out(out4),
        .out_full(out_full), .out_wr_en(wr4), .ovf(ovf4));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] ref_dot(
        input logic [3:0][DW-1:0] a, input logic [3:0][DW-1:0] b,
        input int n, input bit rnd, output bit ov);
        logic signed [127:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++)
            acc += 128'($signed(a[i])) * 128'($signed(b[i]));
        if (rnd) acc += 128'(1 << (QB - 1));
        acc = acc >>> QB;
        ov = (acc > 128'sd2147483647) || (acc < -(128'sd2147483648));
`ifdef DOT_PIPE_SATURATE_EN
        if (ov) return acc[127] ? 32'h8000_0000 : 32'h7fff_ffff;
`endif
        return acc[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd_elem();
        case ($urandom_range(0, 9))
            0:       return $urandom;
            1:       return 32'h8000_0000;
            2:       return 32'h7fff_ffff;
            default: return $urandom_range(0, 2097152) - 32'd1048576;
        endcase
    endfunction

    task automatic add_dir(input int a0, a1, a2, a3, b0, b1, b2, b3,
                           input logic [DW-1:0] gr, gt, g4);
        stim_t t;
        t.a[0] = a0; t.a[1] = a1; t.a[2] = a2; t.a[3] = a3;
        t.b[0] = b0; t.b[1] = b1; t.b[2] = b2; t.b[3] = b3;
        t.g = 1'b1; t.gr = gr; t.gt = gt; t.g4 = g4;
        sq.push_back(t);
    endtask

    task automatic add_rand(input int n);
        stim_t t;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 4; i++) begin
                t.a[i] = rnd_elem();
                t.b[i] = rnd_elem();
            end
            t.g = 1'b0; t.gr = '0; t.gt = '0; t.g4 = '0;
            sq.push_back(t);
        end
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clock);
            done = (sq.size() == 0) && (q.size() == 0);
        end
        chk("drain", 64'(done), 64'd1);
    endtask

    // Driver: pops the stimulus consumed on the previous edge, presents the next.
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            sq.delete();
            in_empty = 1'b1;
            out_full = 1'b0;
        end else begin
            if (took && sq.size() > 0) sq.delete(0);
            took = 1'b0;
            in_empty = (sq.size() == 0) || (gap && $urandom_range(0, 3) == 0);
            if (sq.size() > 0) begin
                xb = sq[0].a;
                yb = sq[0].b;
            end else begin
                xb = {$urandom, $urandom, $urandom, $urandom};
                yb = {$urandom, $urandom, $urandom, $urandom};
            end
            case (bp_mode)
                0: out_full = 1'b0;
                1: out_full = ($urandom_range(0, 2) == 0);
                default: begin
                    out_full = (pc < 5);
                    pc = (pc + 1) % 8;
                end
            endcase
        end
    end

    // Monitor/scoreboard: entries age one step per advancing edge; age 2 = ready.
    always @(negedge clock) begin
        if (!reset) begin
            q.delete();
            ovm_r = 0; ovm_t = 0; ovm4 = 0;
            took = 1'b0;
        end else begin
            head = (q.size() > 0) && (q[0].adv >= 2);
            adv  = !(head && out_full);
            chk("rd_r", 64'(rd_r), 64'(!in_empty && adv));
            chk("rd_t", 64'(rd_t), 64'(!in_empty && adv));
            chk("rd4",  64'(rd4),  64'(!in_empty && adv));
            chk("wr_r", 64'(wr_r), 64'(head && !out_full));
            chk("wr_t", 64'(wr_t), 64'(head && !out_full));
            chk("wr4",  64'(wr4),  64'(head && !out_full));
            if (wr_r) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'(wr_r), 64'd0);
                end else begin
                    e = q.pop_front();
                    n_out++;
                    chk("out_r", 64'(out_r), 64'(e.er));
                    chk("out_t", 64'(out_t), 64'(e.et));
                    chk("out4",  64'(out4),  64'(e.e4));
                    ovm_r |= e.vr; ovm_t |= e.vt; ovm4 |= e.v4;
                    chk("ovf_r", 64'(ovf_r), 64'(ovm_r));
                    chk("ovf_t", 64'(ovf_t), 64'(ovm_t));
                    chk("ovf4",  64'(ovf4),  64'(ovm4));
                    if (e.g) begin
                        chk("gold_r", 64'(out_r), 64'(e.gr));
                        chk("gold_t", 64'(out_t), 64'(e.gt));
                        chk("gold4",  64'(out4),  64'(e.g4));
                    end
                end
            end
            if (adv) begin
                for (int i = 0; i < q.size(); i++) q[i].adv = q[i].adv + 1;
            end
            if (rd_r && sq.size() > 0) begin
                s = sq[0];
                e.er = ref_dot(xb, yb, 3, 1'b1, e.vr);
                e.et = ref_dot(xb, yb, 3, 1'b0, e.vt);
                e.e4 = ref_dot(xb, yb, 4, 1'b1, e.v4);
                e.g = s.g; e.gr = s.gr; e.gt = s.gt; e.g4 = s.g4;
                e.adv = 0;
                q.push_back(e);
                chk("inflight", 64'(q.size() <= 3), 64'd1);
            end
            took = rd_r;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; n_out = 0;
        bp_mode = 0; pc = 0; gap = 1'b0; took = 1'b0;
        reset = 1'b0; in_empty = 1'b1; out_full = 1'b0;
        xb = '0; yb = '0;
        repeat (3) @(negedge clock);
        chk("rst_out_r", 64'(out_r), 64'd0);
        chk("rst_out_t", 64'(out_t), 64'd0);
        chk("rst_out4",  64'(out4),  64'd0);
        chk("rst_wr_r",  64'(wr_r),  64'd0);
        chk("rst_wr4",   64'(wr4),   64'd0);
        chk("rst_ovf_r", 64'(ovf_r), 64'd0);
        chk("rst_ovf4",  64'(ovf4),  64'd0);
        chk("rst_rd_r",  64'(rd_r),  64'd0);
        @(posedge clock); #3 reset = 1'b1;

        add_dir(1024, 2048, 3072, 0, 1024, 1024, 1024, 0,
                32'd6144, 32'd6144, 32'd6144);
        add_dir(-1536, 512, 0, 0, 2048, -2048, 7, 0,
                -32'sd4096, -32'sd4096, -32'sd4096);
        add_dir(1, 0, 0, 0, 512, 0, 0, 0, 32'd1, 32'd0, 32'd1);
        add_dir(1, 0, 0, 0, -512, 0, 0, 0, 32'd0, 32'hffff_ffff, 32'd0);
        add_dir(1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024,
                32'd3072, 32'd3072, 32'd4096);
        drain(100);
        chk("ovf_clean_r", 64'(ovf_r), 64'd0);
        chk("ovf_clean4",  64'(ovf4),  64'd0);

`ifdef DOT_PIPE_SATURATE_EN
        add_dir(1 << 30, 0, 0, 0, 1 << 30, 0, 0, 0,
                32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff);
`else
        add_dir(1 << 30, 0, 0, 0, 1 << 30, 0, 0, 0, 32'd0, 32'd0, 32'd0);
`endif
        drain(100);
        chk("ovf_set_r", 64'(ovf_r), 64'd1);
        chk("ovf_set_t", 64'(ovf_t), 64'd1);
        chk("ovf_set4",  64'(ovf4),  64'd1);

        bp_mode = 2; pc = 0; base = n_out;
        add_rand(10);
        drain(300);
        chk("bp_count", 64'(n_out - base), 64'd10);
        bp_mode = 0;

        bp_mode = 1; gap = 1'b1;
        add_rand(200);
        drain(3000);
        bp_mode = 0; gap = 1'b0;

        add_rand(2);
        begin
            bit ready;
            ready = 1'b0;
            for (int i = 0; i < 20 && !ready; i++) begin
                @(negedge clock); #1;
                ready = (q.size() == 2);
            end
            chk("rst_setup", 64'(ready), 64'd1);
        end
        @(posedge clock); #3 reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_wr_r",  64'(wr_r),  64'd0);
        chk("mid_rst_wr4",   64'(wr4),   64'd0);
        chk("mid_rst_ovf_r", 64'(ovf_r), 64'd0);
        chk("mid_rst_ovf_t", 64'(ovf_t), 64'd0);
        chk("mid_rst_ovf4",  64'(ovf4),  64'd0);
        @(posedge clock); #3 reset = 1'b1;
        base = n_out;
        repeat (10) @(posedge clock);
        chk("no_stale", 64'(n_out - base), 64'd0);

        add_dir(1024, 2048, 3072, 0, 1024, 1024, 1024, 0,
                32'd6144, 32'd6144, 32'd6144);
        drain(100);
        chk("post_rst_count", 64'(n_out - base), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
